layer_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one fully-connected layer instance (M outputs, N inputs, T-bit words, valid/ready streams) between two requesters. Grants the layer to one requester per whole input vector, forwards exactly N input words from it, then routes the M result words back to that requester's response port before re-arbitrating. Sits between two upstream producer/consumer pairs and the layer's s_/m_ stream ports. Only one vector is ever in flight.

---
 rtl/layer_share_arb_if.sv | 12 +
 rtl/layer_share_arb.sv | 139 +++++++++++++
 tb/tb_layer_share_arb.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_share_arb_if.sv
// Valid/ready word stream used for the requester, response and layer-side ports
// of layer_share_arb. master drives valid/data, slave drives ready.
interface layer_share_arb_if #(
  parameter int T = 20
);
  logic         valid;
  logic [T-1:0] data;
  logic         ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/layer_share_arb.sv
// Round-robin arbiter sharing one fully-connected layer between two requesters.
// Optional per-requester completion counters are enabled by defining LAYER_ARB_STATS_EN.
module layer_share_arb #(
  parameter int M = 16,
  parameter int N = 12,
  parameter int T = 20
) (
  input  logic               clk,
  input  logic               reset,
  layer_share_arb_if.slave   req0,
  layer_share_arb_if.slave   req1,
  layer_share_arb_if.master  rsp0,
  layer_share_arb_if.master  rsp1,
  layer_share_arb_if.master  l_s,
  layer_share_arb_if.slave   l_m
`ifdef LAYER_ARB_STATS_EN
  ,
  output logic [15:0]        done_cnt0,
  output logic [15:0]        done_cnt1
`endif
);

  localparam int IN_W  = $clog2(N + 1);
  localparam int OUT_W = $clog2(M + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              grant, grant_nxt;
  logic              last_grant, last_grant_nxt;
  logic [IN_W-1:0]   in_cnt, in_cnt_nxt;
  logic [OUT_W-1:0]  out_cnt, out_cnt_nxt;
  logic              vec_done;

  logic              sel_valid;
  logic [T-1:0]      sel_data;
  logic              sel_rsp_ready;

  assign sel_valid     = grant ? req1.valid : req0.valid;
  assign sel_data      = grant ? req1.data  : req0.data;
  assign sel_rsp_ready = grant ? rsp1.ready : rsp0.ready;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs, independent of statement order.
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      in_cnt     <= '0;
      out_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      in_cnt     <= in_cnt_nxt;
      out_cnt    <= out_cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path
    // through the case leaves a signal unassigned and infers a latch.
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    in_cnt_nxt     = in_cnt;
    out_cnt_nxt    = out_cnt;
    vec_done       = 1'b0;

    req0.ready = 1'b0;
    req1.ready = 1'b0;
    rsp0.valid = 1'b0;
    rsp1.valid = 1'b0;
    rsp0.data  = l_m.data;
    rsp1.data  = l_m.data;
    l_s.valid  = 1'b0;
    l_s.data   = '0;
    l_m.ready  = 1'b0;

    unique case (state)
      IDLE: begin
        if (req0.valid || req1.valid) begin
          // On a tie the requester that was not served last wins.
          grant_nxt  = (req0.valid && req1.valid) ? ~last_grant : req1.valid;
          state_nxt  = LOAD;
          in_cnt_nxt = '0;
        end
      end

      LOAD: begin
        l_s.valid = sel_valid;
        l_s.data  = sel_data;
        if (grant) req1.ready = l_s.ready;
        else       req0.ready = l_s.ready;
        if (sel_valid && l_s.ready) begin
          in_cnt_nxt = in_cnt + 1'b1;
          if (in_cnt == IN_W'(N - 1)) begin
            state_nxt   = DRAIN;
            out_cnt_nxt = '0;
          end
        end
      end

      DRAIN: begin
        if (grant) rsp1.valid = l_m.valid;
        else       rsp0.valid = l_m.valid;
        l_m.ready = sel_rsp_ready;
        if (l_m.valid && sel_rsp_ready) begin
          out_cnt_nxt = out_cnt + 1'b1;
          if (out_cnt == OUT_W'(M - 1)) begin
            vec_done       = 1'b1;
            state_nxt      = IDLE;
            last_grant_nxt = grant;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

`ifdef LAYER_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      done_cnt0 <= '0;
      done_cnt1 <= '0;
    end else if (vec_done) begin
      if (!grant && done_cnt0 != 16'hFFFF) done_cnt0 <= done_cnt0 + 16'd1;
      if (grant  && done_cnt1 != 16'hFFFF) done_cnt1 <= done_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_layer_share_arb.sv
// Directed bench for layer_share_arb with a behavioural FC layer (ReLU(W.x+b)).
// Define LAYER_ARB_STATS_EN to also exercise the completion counters.
module tb_layer_share_arb;

  localparam int M = 16;
  localparam int N = 12;
  localparam int T = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  layer_share_arb_if #(.T(T)) req0_if ();
  layer_share_arb_if #(.T(T)) req1_if ();
  layer_share_arb_if #(.T(T)) rsp0_if ();
  layer_share_arb_if #(.T(T)) rsp1_if ();
  layer_share_arb_if #(.T(T)) ls_if ();
  layer_share_arb_if #(.T(T)) lm_if ();

  logic [1:0]   req_valid;
  logic [T-1:0] req_data [2];
  logic [1:0]   rsp_ready;

  assign req0_if.valid = req_valid[0];
  assign req0_if.data  = req_data[0];
  assign req1_if.valid = req_valid[1];
  assign req1_if.data  = req_data[1];
  assign rsp0_if.ready = rsp_ready[0];
  assign rsp1_if.ready = rsp_ready[1];

`ifdef LAYER_ARB_STATS_EN
  logic [15:0] done_cnt0, done_cnt1;
`endif

  layer_share_arb #(.M(M), .N(N), .T(T)) dut (
    .clk   (clk),
    .reset (reset),
    .req0  (req0_if),
    .req1  (req1_if),
    .rsp0  (rsp0_if),
    .rsp1  (rsp1_if),
    .l_s   (ls_if),
    .l_m   (lm_if)
`ifdef LAYER_ARB_STATS_EN
    ,
    .done_cnt0 (done_cnt0),
    .done_cnt1 (done_cnt1)
`endif
  );

  // Golden fully-connected layer: w(i,j) in -3..3, b(i) = i-8, ReLU output.
  function automatic logic [T-1:0] row_out(input int i, input int xv[N]);
    int acc;
    acc = i - 8;
    for (int j = 0; j < N; j++) acc += (((i * 3 + j * 5) % 7) - 3) * xv[j];
    return (acc < 0) ? '0 : T'(acc);
  endfunction

  // Behavioural layer: collect N words, compute for one cycle, emit M words.
  logic [1:0]   mphase;
  int           lcnt, ocnt, ls_hs;
  int           xs [N];
  logic [T-1:0] ys [M];
  logic         force_mvalid;

  assign ls_if.ready = (mphase == 2'd0);
  assign lm_if.valid = (mphase == 2'd2) || force_mvalid;
  assign lm_if.data  = ys[ocnt];

  always @(posedge clk) begin
    if (ls_if.valid && ls_if.ready && !reset) ls_hs <= ls_hs + 1;
    if (reset) begin
      mphase <= 2'd0;
      lcnt   <= 0;
      ocnt   <= 0;
    end else begin
      case (mphase)
        2'd0: if (ls_if.valid) begin
          xs[lcnt] <= int'($signed(ls_if.data));
          if (lcnt == N - 1) begin
            lcnt   <= 0;
            mphase <= 2'd1;
          end else lcnt <= lcnt + 1;
        end
        2'd1: begin
          for (int i = 0; i < M; i++) ys[i] <= row_out(i, xs);
          mphase <= 2'd2;
        end
        default: if (lm_if.valid && lm_if.ready) begin
          if (ocnt == M - 1) begin
            ocnt   <= 0;
            mphase <= 2'd0;
          end else ocnt <= ocnt + 1;
        end
      endcase
    end
  end

  function automatic logic req_ready_of(input int w);
    return (w == 1) ? req1_if.ready : req0_if.ready;
  endfunction
  function automatic logic rsp_valid_of(input int w);
    return (w == 1) ? rsp1_if.valid : rsp0_if.valid;
  endfunction
  function automatic logic [T-1:0] rsp_data_of(input int w);
    return (w == 1) ? rsp1_if.data : rsp0_if.data;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    force_mvalid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // Stream one vector (x[j] = base+j) from requester who, then drain M results.
  task automatic run_vector(input int who, input int base, input bit bp, input int bubble_at);
    int k, j, cyc, bub, hs0;
    int xv [N];
    logic [T-1:0] held;
    bit held_v, other_bad;
    logic [T-1:0] exp_d;
    for (int i = 0; i < N; i++) xv[i] = base + i;
    hs0 = ls_hs; other_bad = 1'b0; k = 0; cyc = 0; bub = 0;
    while (k < N && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (k == bubble_at && bub < 3) begin
        req_valid[who] = 1'b0;
        bub++;
        #1;
        checks++;
        if (ls_if.valid !== 1'b0 || int'(dut.in_cnt) != bubble_at || int'(dut.state) != 1) begin
          errors++;
          $display("FAIL bubble_hold: l_s_valid=%b in_cnt=%0d state=%0d, need 0/%0d/1",
                   ls_if.valid, dut.in_cnt, dut.state, bubble_at);
        end
      end else begin
        req_valid[who] = 1'b1;
        req_data[who]  = T'(xv[k]);
        #1;
        if (req_ready_of(1 - who) !== 1'b0) other_bad = 1'b1;
        if (req_ready_of(who) === 1'b1) k++;
      end
    end
    checks++;
    if (k != N) begin
      errors++;
      $display("FAIL load_timeout: accepted %0d words, need %0d", k, N);
    end
    @(posedge clk);
    #1;
    req_valid[who] = 1'b0;
    checks++;
    if (ls_hs - hs0 != N) begin
      errors++;
      $display("FAIL layer_in_count: %0d l_s handshakes, need %0d", ls_hs - hs0, N);
    end

    j = 0; cyc = 0; held_v = 1'b0;
    while (j < M && cyc < 400) begin
      @(negedge clk);
      cyc++;
      rsp_ready[who] = bp ? ((cyc % 2) == 1) : 1'b1;
      #1;
      if (rsp_valid_of(1 - who) !== 1'b0 || req_ready_of(1 - who) !== 1'b0) other_bad = 1'b1;
      if (held_v && rsp_valid_of(who)) begin
        checks++;
        if (rsp_data_of(who) !== held) begin
          errors++;
          $display("FAIL rsp_stable: data %h changed from %h while stalled", rsp_data_of(who), held);
        end
      end
      held_v = 1'b0;
      if (rsp_valid_of(who) === 1'b1) begin
        if (rsp_ready[who]) begin
          exp_d = row_out(j, xv);
          checks++;
          if (rsp_data_of(who) !== exp_d) begin
            errors++;
            $display("FAIL rsp%0d_word%0d: got %h need %h", who, j, rsp_data_of(who), exp_d);
          end
          j++;
        end else begin
          held_v = 1'b1;
          held   = rsp_data_of(who);
        end
      end
    end
    checks++;
    if (j != M) begin
      errors++;
      $display("FAIL drain_timeout: received %0d words, need %0d", j, M);
    end
    @(posedge clk);
    #1;
    rsp_ready[who] = 1'b0;
    checks++;
    if (int'(dut.state) != 0 || lm_if.ready !== 1'b0 || rsp_valid_of(who) !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: state=%0d l_m_ready=%b rsp_valid=%b, need 0/0/0",
               dut.state, lm_if.ready, rsp_valid_of(who));
    end
    checks++;
    if (other_bad) begin
      errors++;
      $display("FAIL other_port_quiet: requester %0d saw ready/rsp_valid high, need 0", 1 - who);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (req0_if.ready !== 1'b0 || req1_if.ready !== 1'b0 || rsp0_if.valid !== 1'b0 ||
        rsp1_if.valid !== 1'b0 || ls_if.valid !== 1'b0 || ls_if.data !== '0 || lm_if.ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rr=%b%b rv=%b%b lsv=%b lsd=%h lmr=%b, need all 0",
               req1_if.ready, req0_if.ready, rsp1_if.valid, rsp0_if.valid,
               ls_if.valid, ls_if.data, lm_if.ready);
    end
    checks++;
    if (dut.last_grant !== 1'b1 || int'(dut.in_cnt) != 0 || int'(dut.out_cnt) != 0) begin
      errors++;
      $display("FAIL reset_regs: last_grant=%b in_cnt=%0d out_cnt=%0d, need 1/0/0",
               dut.last_grant, dut.in_cnt, dut.out_cnt);
    end
    force_mvalid = 1'b1;
    rsp_ready = 2'b11;
    #1;
    checks++;
    if (lm_if.ready !== 1'b0 || rsp0_if.valid !== 1'b0 || rsp1_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_m_valid: l_m_ready=%b rsp_valid=%b%b, need 0/00",
               lm_if.ready, rsp1_if.valid, rsp0_if.valid);
    end
    force_mvalid = 1'b0;
    rsp_ready = 2'b00;
  endtask

  task automatic test_single();
    do_reset();
    run_vector(0, 1, 1'b0, -1);
  endtask

  task automatic test_tie();
    do_reset();
    @(negedge clk);
    req_valid = 2'b11;
    req_data[0] = T'(3);
    req_data[1] = T'(50);
    #1;
    checks++;
    if (req0_if.ready !== 1'b0 || req1_if.ready !== 1'b0 || ls_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_forward: ready=%b%b l_s_valid=%b, need 00/0",
               req1_if.ready, req0_if.ready, ls_if.valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (req0_if.ready !== 1'b1 || req1_if.ready !== 1'b0) begin
      errors++;
      $display("FAIL tie_first: ready=%b%b, need 01", req1_if.ready, req0_if.ready);
    end
    run_vector(0, 3, 1'b0, -1);
    run_vector(1, 50, 1'b0, -1);
    req_valid = 2'b11;
    req_data[0] = T'(7);
    req_data[1] = T'(60);
    @(posedge clk);
    #1;
    checks++;
    if (req0_if.ready !== 1'b1 || req1_if.ready !== 1'b0) begin
      errors++;
      $display("FAIL tie_third: ready=%b%b, need 01", req1_if.ready, req0_if.ready);
    end
    run_vector(0, 7, 1'b0, -1);
    req_valid[1] = 1'b0;
  endtask

  task automatic test_back_pressure();
    do_reset();
    run_vector(1, 30, 1'b1, -1);
  endtask

  task automatic test_bubble();
    do_reset();
    run_vector(0, 20, 1'b0, 5);
  endtask

  task automatic test_mid_reset();
    int k, cyc;
    do_reset();
    k = 0; cyc = 0;
    while (k < 7 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      req_valid[0] = 1'b1;
      req_data[0]  = T'(100 + k);
      #1;
      if (req0_if.ready === 1'b1) k++;
    end
    @(negedge clk);
    reset = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (int'(dut.state) != 0 || int'(dut.in_cnt) != 0 || dut.last_grant !== 1'b1 ||
        ls_if.valid !== 1'b0 || ls_if.data !== '0 || req0_if.ready !== 1'b0 || lm_if.ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: state=%0d in_cnt=%0d last_grant=%b lsv=%b lsd=%h rr0=%b lmr=%b",
               dut.state, dut.in_cnt, dut.last_grant, ls_if.valid, ls_if.data,
               req0_if.ready, lm_if.ready);
    end
    run_vector(0, -10, 1'b0, -1);
  endtask

`ifdef LAYER_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    run_vector(0, 2, 1'b0, -1);
    run_vector(1, 4, 1'b0, -1);
    run_vector(0, 6, 1'b0, -1);
    run_vector(1, 8, 1'b1, -1);
    run_vector(0, 9, 1'b0, -1);
    checks++;
    if (done_cnt0 !== 16'd3 || done_cnt1 !== 16'd2) begin
      errors++;
      $display("FAIL stats_count: done_cnt0=%0d done_cnt1=%0d, need 3/2", done_cnt0, done_cnt1);
    end
    do_reset();
    checks++;
    if (done_cnt0 !== 16'd0 || done_cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL stats_reset: done_cnt0=%0d done_cnt1=%0d, need 0/0", done_cnt0, done_cnt1);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    req_valid = 2'b00;
    req_data[0] = '0;
    req_data[1] = '0;
    rsp_ready = 2'b00;
    force_mvalid = 1'b0;
    ls_hs = 0;
    test_reset();
    test_single();
    test_tie();
    test_back_pressure();
    test_bubble();
    test_mid_reset();
`ifdef LAYER_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
